i2s_capture: RTL

//  - I2S receive stage; sits downstream of the I2S transmit controller (loopback/capture path) or on an external ADC/codec link.
//  - Samples i2s_clock/i2s_lr/i2s_data with the system clk and deserialises MSB-first I2S frames into DATA_WIDTH samples tagged L/R.
//  - Buffers samples in a small FIFO for a wishbone/DMA consumer using the audio_data_valid/audio_data_ack handshake.

---
 rtl/i2s_capture_pkg.sv | 16 +
 rtl/i2s_capture_fifo.sv | 67 ++++++
 rtl/i2s_capture.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/i2s_capture_pkg.sv
// Shared I2S capture types: channel codes and deserialiser FSM state encodings.
package i2s_capture_pkg;

    typedef enum logic {
        I2S_LEFT  = 1'b0,
        I2S_RIGHT = 1'b1
    } i2s_chan_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } cap_state_e;

endpackage

// File: rtl/i2s_capture_fifo.sv
// First-word-fall-through sample FIFO; head visible combinationally, and the last popped word is held while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module i2s_capture_fifo
    import i2s_capture_pkg::*;
#(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_dat_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] last_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign head_dat_o = empty_o ? last_q : mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/i2s_capture.sv
// I2S receiver: deserialises MSB-first slots into L/R-tagged samples, buffered in a FWFT FIFO (sample valid 1 clk after its last bit edge).
// Define I2S_CAPTURE_SYNC_EN for 2-flop pin synchronisers (+1 clk latency) when the codec is asynchronous to clk.
module i2s_capture
    import i2s_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        clear_overflow,
    input  logic                        i2s_clock,
    input  logic                        i2s_lr,
    input  logic                        i2s_data,
    output logic [DATA_WIDTH-1:0]       audio_data,
    output logic                        audio_lr_bit,
    output logic                        audio_data_valid,
    input  logic                        audio_data_ack,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    // Pin stage, packed as {clock, lr, data}.
    logic [2:0] pin_q;
`ifdef I2S_CAPTURE_SYNC_EN
    logic [2:0] meta_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= '0;
            pin_q  <= '0;
        end else begin
            meta_q <= {i2s_clock, i2s_lr, i2s_data};
            pin_q  <= meta_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            pin_q <= '0;
        end else begin
            pin_q <= {i2s_clock, i2s_lr, i2s_data};
        end
    end
`endif

    logic       bclk_prev_q;
    i2s_chan_e  prev_lr_q;
    i2s_chan_e  lr_now;
    logic       bit_edge;
    logic       lr_change;

    assign lr_now    = i2s_chan_e'(pin_q[1]);
    assign bit_edge  = pin_q[2] && !bclk_prev_q;
    assign lr_change = bit_edge && (lr_now != prev_lr_q);

    cap_state_e            state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] shifted;
    i2s_chan_e             frame_lr_q, frame_lr_d;
    logic                  push;
    logic [DATA_WIDTH:0]   push_dat;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        frame_lr_d = frame_lr_q;
        push       = 1'b0;
        push_dat   = {frame_lr_q, shift_q};
        shifted    = {shift_q[DATA_WIDTH-2:0], pin_q[0]};

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SYNC;
                ST_SYNC, ST_HOLD: begin
                    if (lr_change) begin
                        state_d    = ST_SHIFT;
                        bit_cnt_d  = '0;
                        shift_d    = '0;
                        frame_lr_d = lr_now;
                    end
                end
                ST_SHIFT: begin
                    if (lr_change) begin
                        // Short slot: left-align what arrived, missing LSBs read as zero.
                        push       = (bit_cnt_q != '0);
                        push_dat   = {frame_lr_q, shift_q << (CW'(DATA_WIDTH) - bit_cnt_q)};
                        bit_cnt_d  = '0;
                        shift_d    = '0;
                        frame_lr_d = lr_now;
                    end else if (bit_edge) begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        if (bit_cnt_d == CW'(DATA_WIDTH)) begin
                            push     = 1'b1;
                            push_dat = {frame_lr_q, shifted};
                            state_d  = ST_HOLD;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bclk_prev_q <= 1'b0;
            prev_lr_q   <= I2S_LEFT;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_lr_q  <= I2S_LEFT;
        end else begin
            bclk_prev_q <= pin_q[2];
            if (bit_edge) begin
                prev_lr_q <= lr_now;
            end
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            frame_lr_q <= frame_lr_d;
        end
    end

    logic [DATA_WIDTH:0] head_dat;
    logic                fifo_empty;
    logic                fifo_full;
    logic                drop;
    logic                overflow_q, overflow_d;

    i2s_capture_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_ni     (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (audio_data_ack),
        .head_dat_o (head_dat),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .count_o    (fifo_count)
    );

    assign drop = push && fifo_full && !audio_data_ack;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign audio_data       = head_dat[DATA_WIDTH-1:0];
    assign audio_lr_bit     = head_dat[DATA_WIDTH];
    assign audio_data_valid = !fifo_empty;
    assign overflow         = overflow_q;

endmodule
